// File: rtl/share_unmasker_if.sv
// Stream bundle for share_unmasker: serial share input and recombined word output.
// The slave modport is the unmasker's view, and the master modport is the producer/consumer's view.
interface share_unmasker_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_share;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_share, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_share, in_last, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/share_unmasker.sv
// Collects NSHARES Boolean shares into separate registers and XOR-recombines them only after the frame is complete.
// Defining SHARE_UNMASKER_SCRUB_EN adds a SCRUB cycle that zeroes every share register after each output handshake.
module share_unmasker #(
  parameter int WIDTH   = 8,
  parameter int NSHARES = 2
) (
  input  logic C,
  input  logic RN,
  share_unmasker_if.slave bus
);
  localparam int CW = $clog2(NSHARES);
  localparam logic [CW-1:0] LAST_IDX = CW'(NSHARES - 1);

`ifdef SHARE_UNMASKER_SCRUB_EN
  typedef enum logic [1:0] {COLLECT, COMBINE, OUT, SCRUB} state_t;
`else
  typedef enum logic [1:0] {COLLECT, COMBINE, OUT} state_t;
`endif

  state_t                          state_reg;
  logic [CW-1:0]                   cnt_reg;
  logic                            err_reg;
  logic                            in_ready_reg;
  logic                            out_valid_reg;
  logic                            out_err_reg;
  logic [WIDTH-1:0]                out_data_reg;
  logic [NSHARES-1:0][WIDTH-1:0]   share_vec;
  logic [WIDTH-1:0]                xor_all;
  logic                            accept;
  logic                            last_idx;
  logic                            frame_bad;
  logic                            scrub;

  assign accept    = in_ready_reg && bus.in_valid;
  assign last_idx  = (cnt_reg == LAST_IDX);
  assign frame_bad = bus.in_last ^ last_idx;

`ifdef SHARE_UNMASKER_SCRUB_EN
  assign scrub = (state_reg == SCRUB);
`else
  assign scrub = 1'b0;
`endif

  // Each share has its own register, so shares never mix until COMBINE.
  genvar gi;
  generate
    for (gi = 0; gi < NSHARES; gi++) begin : g_share
      logic [WIDTH-1:0] share_reg;
      always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
          share_reg <= '0;
        end else if (scrub) begin
          share_reg <= '0;
        end else if (accept && (cnt_reg == CW'(gi))) begin
          share_reg <= bus.in_share;
        end
      end
      assign share_vec[gi] = share_reg;
    end
  endgenerate

  // The XOR tree is fed only from the share registers and never from in_share.
  always_comb begin
    xor_all = '0;
    for (int i = 0; i < NSHARES; i++) begin
      xor_all = xor_all ^ share_vec[i];
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state_reg     <= COLLECT;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            if (frame_bad) begin
              err_reg <= 1'b1;
            end
            if (last_idx) begin
              cnt_reg      <= '0;
              in_ready_reg <= 1'b0;
              state_reg    <= COMBINE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        COMBINE: begin
          out_data_reg  <= xor_all;
          out_err_reg   <= err_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
`ifdef SHARE_UNMASKER_SCRUB_EN
            state_reg     <= SCRUB;
`else
            in_ready_reg  <= 1'b1;
            state_reg     <= COLLECT;
`endif
          end
        end
`ifdef SHARE_UNMASKER_SCRUB_EN
        SCRUB: begin
          err_reg      <= 1'b0;
          in_ready_reg <= 1'b1;
          state_reg    <= COLLECT;
        end
`endif
        default: begin
          cnt_reg       <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          state_reg     <= COLLECT;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_err   = out_err_reg;
endmodule

// File: tb/tb_share_unmasker.sv
// Self-checking bench for share_unmasker (NSHARES=3): directed frames plus randomized frames checked against a frame-level XOR/framing model.
module tb_share_unmasker;
  localparam int W = 8;
  localparam int N = 3;

  logic C  = 1'b0;
  logic RN = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   frame_no = 0;

  share_unmasker_if #(.WIDTH(W)) bus ();

  share_unmasker #(.WIDTH(W), .NSHARES(N)) dut (
    .C   (C),
    .RN  (RN),
    .bus (bus)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  // Offer the N shares of one frame, with an optional idle gap before every share after the first.
  task automatic push_shares(input logic [W-1:0] sh [N], input logic lst [N], input int gap);
    for (int i = 0; i < N; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          tick();
          chk("gap_in_ready", 32'(bus.in_ready), 32'd1);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_share = sh[i];
      bus.in_last  = lst[i];
      chk("in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
  endtask

  task automatic run_frame(input logic [W-1:0] sh [N], input logic lst [N], input int gap, input int stall);
    logic [W-1:0] exp_d;
    logic         exp_e;
    exp_d = '0;
    exp_e = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_d = exp_d ^ sh[i];
      if (lst[i] != (i == N - 1)) exp_e = 1'b1;
    end
    push_shares(sh, lst, gap);
    // COMBINE cycle: a share offered here must be ignored.
    bus.in_valid = 1'b1;
    bus.in_share = W'($urandom);
    bus.in_last  = 1'b0;
    chk("combine_out_valid", 32'(bus.out_valid), 32'd0);
    chk("combine_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    for (int s = 0; s <= stall; s++) begin
      bus.out_ready = (s == stall);
      bus.in_valid  = 1'($urandom_range(1));
      bus.in_share  = W'($urandom);
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("out_data", 32'(bus.out_data), 32'(exp_d));
      chk("out_err", 32'(bus.out_err), 32'(exp_e));
      chk("out_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
`ifdef SHARE_UNMASKER_SCRUB_EN
    chk("scrub_in_ready", 32'(bus.in_ready), 32'd0);
    chk("scrub_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
`endif
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_data_hold", 32'(bus.out_data), 32'(exp_d));
    $display("frame %0d shares=%h,%h,%h last=%b%b%b gap=%0d stall=%0d -> data=%h err=%b",
             frame_no, sh[0], sh[1], sh[2], lst[0], lst[1], lst[2], gap, stall, exp_d, exp_e);
    frame_no++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_out_err"}, 32'(bus.out_err), 32'd0);
  endtask

  initial begin
    logic [W-1:0] sh [N];
    logic         lst [N];
    logic         ok_lst [N];
    bus.in_valid  = 1'b0;
    bus.in_share  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    ok_lst = '{1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge C);
    #1;
    chk_reset_outputs("reset");
    RN = 1'b1;
    tick();

    sh = '{8'hA5, 8'h3C, 8'h0F};
    run_frame(sh, ok_lst, 0, 0);
    lst = '{1'b0, 1'b1, 1'b0};
    run_frame(sh, lst, 0, 0);
    run_frame(sh, ok_lst, 0, 0);
    run_frame(sh, ok_lst, 0, 5);

    sh = '{8'hFF, 8'h0F, 8'h00};
    run_frame(sh, ok_lst, 1, 0);

    // Reset mid-frame after two shares, and the partial frame is discarded.
    sh = '{8'h55, 8'h66, 8'h77};
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_share = sh[i];
      bus.in_last  = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    #2 RN = 1'b0;
    #1 chk_reset_outputs("midframe_rst");
    tick();
    RN = 1'b1;
    tick();
    sh = '{8'h01, 8'h02, 8'h04};
    run_frame(sh, ok_lst, 0, 0);

    // Reset while OUT is stalled: out_valid must drop without a clock edge.
    sh = '{8'h12, 8'h34, 8'h56};
    push_shares(sh, ok_lst, 0);
    bus.in_valid = 1'b0;
    tick();
    chk("stalled_out_valid", 32'(bus.out_valid), 32'd1);
    #2 RN = 1'b0;
    #1 chk_reset_outputs("out_rst");
    tick();
    RN = 1'b1;
    tick();

    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) sh[i] = W'($urandom);
      if ($urandom_range(3) == 0) begin
        for (int i = 0; i < N; i++) lst[i] = 1'($urandom_range(1));
      end else begin
        lst = ok_lst;
      end
      run_frame(sh, lst, int'($urandom_range(1)), int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/share_unmasker.md
# share_unmasker

Receive-side counterpart of the masking encoder in the masked-netlist flow. Accepts the NSHARES Boolean shares of one secret word serially over a valid/ready stream. Holds each share in its own register and recombines them by XOR only once the frame is complete. Presents the unmasked word on a valid/ready output, so share registers never mix before the frame boundary and the result is probe-friendly for leakage evaluation.

## Interface
- WIDTH, 8, bit width of each share and of the recombined word.
- NSHARES, 2, shares per frame; legal range 2..16.
- C  input  1  clock, rising edge.
- RN  input  1  asynchronous reset, active low.
- in_valid  input  1  a share is offered on in_share.
- in_ready  output  1  block accepts a share this cycle.
- in_share  input  WIDTH  share value.
- in_last  input  1  producer marks the final share of the frame.
- out_valid  output  1  recombined word available.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  XOR of all NSHARES shares of the frame.
- out_err  output  1  framing error for the frame on out_data; valid while out_valid.

## Operation
- Clock port is C and reset is RN. RN is asynchronous and active low.
- Reset state: state=COLLECT, share index cnt=0, all share registers 0, out_data=0, out_err=0, out_valid=0, in_ready=1.
- State machine: COLLECT -> COMBINE -> OUT -> COLLECT. With the scrub feature enabled, the sequence is COLLECT -> COMBINE -> OUT -> SCRUB -> COLLECT.
- COLLECT:
  - in_ready=1.
  - On in_valid&&in_ready: share_q[cnt] <= in_share, then cnt increments.
  - When the accepted share is index NSHARES-1, cnt wraps to 0 and the state becomes COMBINE.
- Framing check: err_q is set if in_last=1 is accepted with cnt!=NSHARES-1, or if in_last=0 is accepted with cnt==NSHARES-1. err_q clears on entry to COLLECT from OUT or SCRUB.
- A frame is always exactly NSHARES accepted shares. in_last only drives the error flag and never shortens or extends a frame.
- COMBINE:
  - in_ready=0.
  - out_data <= XOR of share_q[0..NSHARES-1], and out_err <= err_q.
  - Then state becomes OUT.
- The XOR tree is driven only from share registers. No in_share bit reaches the tree combinationally.
- OUT:
  - out_valid=1 and in_ready=0.
  - out_data and out_err are held stable until out_valid&&out_ready.
  - On that handshake, state goes to COLLECT, or to SCRUB when the scrub feature is enabled.
- out_data keeps its last value after the handshake. It only changes in COMBINE.
- Valid/ready rule: a transfer occurs only on a rising edge where valid and ready are both 1. in_ready and out_valid depend only on state, never combinationally on in_valid or out_ready.

## Timing
- One share per cycle in COLLECT.
- Latency: the last share is accepted at edge E0, COMBINE is the cycle after E0, and out_valid rises at edge E0+1.
- With out_ready held at 1: out_valid is high for exactly 1 cycle, and in_ready rises 1 cycle later, or 2 cycles later with scrub.
- Throughput: NSHARES+2 cycles per word, or NSHARES+3 with scrub.
- in_valid while not in COLLECT: ignored, and nothing is accepted.
- Back-to-back frames: sharing the cycle with OUT is not allowed. The next frame's first share is accepted no earlier than the edge after the OUT handshake.
- RN asserted at any point, including mid-frame or while OUT is stalled: the block returns to the reset state immediately, the partial frame is discarded, and out_valid drops asynchronously.

## Configuration
- Macro: SHARE_UNMASKER_SCRUB_EN.
- Defined: after the OUT handshake, the block spends one SCRUB cycle with in_ready=0 that writes 0 to every share_q and to err_q, then enters COLLECT. No share survives into the next frame.
- Undefined: there is no SCRUB state. share_q keeps stale values until overwritten.
- Functional output values are identical in both builds; only the timing differs.

## Test plan
- WIDTH=8, NSHARES=3; shares 0xA5, 0x3C, 0x0F on consecutive cycles with in_last on the third -> out_valid at E0+1 with out_data=0x96 and out_err=0.
- Same frame with in_last asserted on the second share -> still 3 shares accepted, out_data=0x96, out_err=1; the next clean frame reports out_err=0.
- out_ready held 0 for 5 cycles in OUT -> out_valid and out_data stay stable, in_ready=0, and in_valid pulses are ignored; releasing out_ready completes the handshake.
- Gapped in_valid (one idle cycle between shares), NSHARES=2, shares 0xFF, 0x0F -> out_data=0xF0.
- RN pulsed low after 2 of 3 shares -> all outputs at reset values; a new full frame of 0x01, 0x02, 0x04 -> out_data=0x07.
- With SHARE_UNMASKER_SCRUB_EN defined -> one extra in_ready=0 cycle after the OUT handshake, and every share_q reads 0 in the first COLLECT cycle. Without the macro, in_ready rises directly.
